// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: register indexing and bypass-select encodings.
package hazard_unit_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Bypass mux select driven into the E stage.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    // A source register depends on a destination only when it is a real
    // register: $zero is hardwired and never carries a dependency.
    function automatic logic reg_match(reg_idx_t src, reg_idx_t dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_unit_md_scoreboard.sv
// HI/LO busy scoreboard: counts down the multi-cycle mult/div latency after
// an md op leaves E, and flags an md op issued while the unit is still busy.
module md_scoreboard #(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic mdstart,
    output logic mdbusy,
    output logic mderr
);

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES);

    logic [7:0] mdcnt;

    // Busy countdown plus sticky misuse flag; a start while busy neither
    // reloads nor extends the countdown.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdcnt <= 8'd0;
            mderr <= 1'b0;
        end else begin
            if (mdcnt == 8'd0) begin
                if (mdstart) begin
                    mdcnt <= MD_LOAD;
                end
            end else begin
                mdcnt <= mdcnt - 8'd1;
            end
            if (mdstart && (mdcnt != 8'd0)) begin
                mderr <= 1'b1;
            end
        end
    end

    // Busy comes only from the register so it never depends on inputs.
    assign mdbusy = (mdcnt != 8'd0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control for the 5-stage core: bypass selects, load-use,
// branch-compare and HI/LO stalls, flushes, and a stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MD_CYCLES = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             branchD,
    input  logic             pcsrcD,
    input  logic             jumpD,
    input  logic             hiloreadD,
    input  logic             mdstartD,
    input  logic             mdstartE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             mdbusy,
    output logic             mderr,
    output logic [CNT_W-1:0] stallcnt
);

    fwd_sel_e fwd_ae;
    fwd_sel_e fwd_be;
    logic     lwstall;
    logic     branchstall;
    logic     mdstall;
    logic     stall;

    md_scoreboard #(
        .MD_CYCLES(MD_CYCLES)
    ) u_md_scoreboard (
        .clk    (clk),
        .reset  (reset),
        .mdstart(mdstartE),
        .mdbusy (mdbusy),
        .mderr  (mderr)
    );

    // E-stage bypass selects; the younger result in M wins over W.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fwd_ae = FWD_RF;
        fwd_be = FWD_RF;
        if (regwriteM && reg_match(rsE, writeregM)) begin
            fwd_ae = FWD_M;
        end else if (regwriteW && reg_match(rsE, writeregW)) begin
            fwd_ae = FWD_W;
        end
        if (regwriteM && reg_match(rtE, writeregM)) begin
            fwd_be = FWD_M;
        end else if (regwriteW && reg_match(rtE, writeregW)) begin
            fwd_be = FWD_W;
        end
    end

    assign forwardAE = fwd_ae;
    assign forwardBE = fwd_be;

    // Branch compare in D can only bypass from M.
    assign forwardAD = regwriteM && reg_match(rsD, writeregM);
    assign forwardBD = regwriteM && reg_match(rtD, writeregM);

    // Stall sources: load result not ready for D, branch operand still in
    // flight, or HI/LO access while the multiplier is (about to be) busy.
    always_comb begin
        lwstall     = memtoregE && (reg_match(rsD, rtE) || reg_match(rtD, rtE));
        branchstall = branchD &&
                      ((regwriteE && (reg_match(rsD, writeregE) || reg_match(rtD, writeregE))) ||
                       (memtoregM && (reg_match(rsD, writeregM) || reg_match(rtD, writeregM))));
        mdstall     = (hiloreadD || mdstartD) && (mdbusy || mdstartE);
        stall       = lwstall || branchstall || mdstall;
    end

    // A stalled redirect must not squash the instruction being held in D.
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;
    assign flushD = (pcsrcD || jumpD) && !stall;

    // Saturating count of stalled cycles; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallcnt <= '0;
        end else if (stall && (stallcnt != '1)) begin
            stallcnt <= stallcnt + CNT_W'(1);
        end
    end

endmodule
